// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider sequencer.
package clk_div_pkg;

   localparam int unsigned DIV_W = 32;
   localparam logic [DIV_W-1:0] RESET_DIV = 32'd1;

   typedef enum logic [1:0] {
      ST_STEADY = 2'd0,
      ST_GATE   = 2'd1,
      ST_LOAD   = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_div_sequencer_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past the winner on advance.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant     = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!grant_vld && req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && grant_vld)
         ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/clk_div_sequencer.sv
// Shares one clock divider among several requesters. Each ratio change is a glitch-free
// sequence: gate the output, load the ratio, let it settle, then re-enable.
module clk_div_sequencer
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_REQ       = 4,
   parameter  int unsigned GATE_CYCLES   = 4,
   parameter  int unsigned SETTLE_CYCLES = 2,
   localparam int unsigned IDX_W         = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     run_en,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [DIV_W*NUM_REQ-1:0] req_div,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [DIV_W-1:0]         div,
   output logic                     div_valid,
   output logic                     div_clk_en,
   output logic [DIV_W-1:0]         cur_div,
   output logic [IDX_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     err_zero
);

   localparam int unsigned CNT_W = $clog2(max_u(GATE_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   cur_div_q, cur_div_d;
   logic [DIV_W-1:0]   new_div_q, new_div_d;
   logic               div_valid_q, div_valid_d;
   logic               div_clk_en_q, div_clk_en_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic               busy_q, busy_d;
   logic               err_zero_q, err_zero_d;

   logic               in_steady;
   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic               accept;
   logic [DIV_W-1:0]   sel_div;

   assign in_steady = (state_q == ST_STEADY);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req_valid),
      .advance   (in_steady),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   assign req_ready = in_steady ? arb_grant : '0;
   assign accept    = in_steady && arb_vld;
   assign sel_div   = req_div[32'(arb_idx) * DIV_W +: DIV_W];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      cur_div_d    = cur_div_q;
      new_div_d    = new_div_q;
      div_valid_d  = 1'b0;
      div_clk_en_d = div_clk_en_q;
      grant_id_d   = grant_id_q;
      err_zero_d   = 1'b0;
      unique case (state_q)
         ST_STEADY: begin
            div_clk_en_d = run_en;
            if (accept) begin
               grant_id_d = arb_idx;
               new_div_d  = sel_div;
               // Zero and unchanged ratios are consumed without touching the divider.
               if (sel_div == '0) begin
                  err_zero_d = 1'b1;
               end else if (sel_div != cur_div_q) begin
                  state_d      = ST_GATE;
                  cnt_d        = '0;
                  div_clk_en_d = 1'b0;
               end
            end
         end
         ST_GATE: begin
            div_clk_en_d = 1'b0;
            if (cnt_q == GATE_LAST) begin
               state_d     = ST_LOAD;
               div_d       = new_div_q;
               cur_div_d   = new_div_q;
               div_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOAD: begin
            state_d      = ST_SETTLE;
            cnt_d        = '0;
            div_clk_en_d = 1'b0;
         end
         ST_SETTLE: begin
            div_clk_en_d = 1'b0;
            if (cnt_q == SETTLE_LAST) begin
               state_d      = ST_STEADY;
               div_clk_en_d = run_en;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_STEADY;
      endcase
      busy_d = (state_d != ST_STEADY);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_STEADY;
         cnt_q        <= '0;
         div_q        <= RESET_DIV;
         cur_div_q    <= RESET_DIV;
         new_div_q    <= RESET_DIV;
         div_valid_q  <= 1'b0;
         div_clk_en_q <= 1'b0;
         grant_id_q   <= '0;
         busy_q       <= 1'b0;
         err_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         cur_div_q    <= cur_div_d;
         new_div_q    <= new_div_d;
         div_valid_q  <= div_valid_d;
         div_clk_en_q <= div_clk_en_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
         err_zero_q   <= err_zero_d;
      end
   end

   assign div        = div_q;
   assign div_valid  = div_valid_q;
   assign div_clk_en = div_clk_en_q;
   assign cur_div    = cur_div_q;
   assign grant_id   = grant_id_q;
   assign busy       = busy_q;
   assign err_zero   = err_zero_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer with default parameters (4 requesters, gate 4, settle 2).
module tb_clk_div_sequencer;

   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            run_en = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [32*NR-1:0] req_div = '0;
   logic [NR-1:0]   req_ready;
   logic [31:0]     div;
   logic            div_valid;
   logic            div_clk_en;
   logic [31:0]     cur_div;
   logic [1:0]      grant_id;
   logic            busy;
   logic            err_zero;

   int checks = 0;
   int errors = 0;

   clk_div_sequencer #(.NUM_REQ(NR), .GATE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .run_en     (run_en),
      .req_valid  (req_valid),
      .req_div    (req_div),
      .req_ready  (req_ready),
      .div        (div),
      .div_valid  (div_valid),
      .div_clk_en (div_clk_en),
      .cur_div    (cur_div),
      .grant_id   (grant_id),
      .busy       (busy),
      .err_zero   (err_zero)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; run_en = 1'b1; req_valid = '0; req_div = '0;
      repeat (2) tick;
      @(negedge clk);
      checks++;
      if ({div_valid, div_clk_en, busy, err_zero} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {div_valid, div_clk_en, busy, err_zero});
      end
      checks++;
      if (div !== 32'd1 || cur_div !== 32'd1) begin
         errors++; $display("FAIL reset_div got div=%0d cur=%0d exp 1/1", div, cur_div);
      end
      checks++;
      if (req_ready !== 4'b0000 || grant_id !== 2'd0) begin
         errors++; $display("FAIL reset_ready got ready=%b gid=%0d exp 0000/0", req_ready, grant_id);
      end
      tick;
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (div_clk_en !== 1'b0) begin
         errors++; $display("FAIL reset_release_en got %b exp 0", div_clk_en);
      end
      for (int k = 1; k <= 4; k++) begin
         tick;
         @(negedge clk);
         checks++;
         if (div_clk_en !== 1'b1 || div_valid !== 1'b0 || div !== 32'd1) begin
            errors++;
            $display("FAIL idle_run k=%0d got en=%b dv=%b div=%0d exp 1/0/1", k, div_clk_en, div_valid, div);
         end
      end
   endtask

   task automatic test_single_ratio;
      logic [2:0] exp_v;
      tick;
      req_valid = 4'b0010; req_div[32 +: 32] = 32'd6;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010 || div_clk_en !== 1'b1) begin
         errors++; $display("FAIL single_accept got ready=%b en=%b exp 0010/1", req_ready, div_clk_en);
      end
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k == 1) req_valid = '0;
         @(negedge clk);
         exp_v = {k == 5, k == 8, k <= 7};
         checks++;
         if ({div_valid, div_clk_en, busy} !== exp_v) begin
            errors++; $display("FAIL single_seq k=%0d got dv/en/busy=%b exp %b", k, {div_valid, div_clk_en, busy}, exp_v);
         end
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_ready k=%0d got %b exp 0000", k, req_ready);
         end
         if (k >= 5) begin
            checks++;
            if (div !== 32'd6) begin
               errors++; $display("FAIL single_div k=%0d got %0d exp 6", k, div);
            end
         end
      end
      checks++;
      if (cur_div !== 32'd6 || grant_id !== 2'd1) begin
         errors++; $display("FAIL single_final got cur=%0d gid=%0d exp 6/1", cur_div, grant_id);
      end
   endtask

   task automatic test_round_robin;
      int         exp_g [3] = '{0, 2, 3};
      int         exp_d [3] = '{3, 4, 5};
      logic [3:0] one;
      logic [2:0] exp_v;
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      tick;
      req_valid = 4'b1101;
      req_div[0 +: 32] = 32'd3; req_div[64 +: 32] = 32'd4; req_div[96 +: 32] = 32'd5;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         one = 4'(1) << exp_g[j];
         checks++;
         if (req_ready !== one || div_clk_en !== 1'b1) begin
            errors++; $display("FAIL rr_grant j=%0d got ready=%b en=%b exp %b/1", j, req_ready, div_clk_en, one);
         end
         for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 1) req_valid[exp_g[j]] = 1'b0;
            @(negedge clk);
            exp_v = {k == 5, k == 8, k <= 7};
            checks++;
            if ({div_valid, div_clk_en, busy} !== exp_v) begin
               errors++; $display("FAIL rr_seq j=%0d k=%0d got %b exp %b", j, k, {div_valid, div_clk_en, busy}, exp_v);
            end
            if (k == 1) begin
               checks++;
               if (grant_id !== 2'(exp_g[j])) begin
                  errors++; $display("FAIL rr_gid j=%0d got %0d exp %0d", j, grant_id, exp_g[j]);
               end
            end
            if (k == 5) begin
               checks++;
               if (div !== 32'(exp_d[j])) begin
                  errors++; $display("FAIL rr_div j=%0d got %0d exp %0d", j, div, exp_d[j]);
               end
            end
         end
      end
      checks++;
      if (cur_div !== 32'd5 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL rr_final got cur=%0d ready=%b exp 5/0000", cur_div, req_ready);
      end
   endtask

   task automatic test_zero_and_same;
      tick;
      req_valid = 4'b0001; req_div[0 +: 32] = 32'd0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL zero_accept got %b exp 0001", req_ready);
      end
      tick;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({err_zero, div_clk_en, busy, div_valid} !== 4'b1100) begin
         errors++; $display("FAIL zero_pulse got err/en/busy/dv=%b exp 1100", {err_zero, div_clk_en, busy, div_valid});
      end
      checks++;
      if (cur_div !== 32'd5 || grant_id !== 2'd0) begin
         errors++; $display("FAIL zero_state got cur=%0d gid=%0d exp 5/0", cur_div, grant_id);
      end
      tick;
      @(negedge clk);
      checks++;
      if (err_zero !== 1'b0) begin
         errors++; $display("FAIL zero_one_cycle got %b exp 0", err_zero);
      end
      tick;
      req_valid = 4'b0010; req_div[32 +: 32] = 32'd5;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL same_accept got %b exp 0010", req_ready);
      end
      for (int k = 1; k <= 3; k++) begin
         tick;
         if (k == 1) req_valid = '0;
         @(negedge clk);
         checks++;
         if ({div_clk_en, busy, div_valid, err_zero} !== 4'b1000 || cur_div !== 32'd5 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL same_nogate k=%0d got en/busy/dv/err=%b cur=%0d gid=%0d exp 1000/5/1",
                     k, {div_clk_en, busy, div_valid, err_zero}, cur_div, grant_id);
         end
      end
   endtask

   task automatic test_run_en_gate;
      logic [2:0] exp_v;
      tick;
      req_valid = 4'b0100; req_div[64 +: 32] = 32'd7;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL runen_accept got %b exp 0100", req_ready);
      end
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k == 1) req_valid = '0;
         if (k == 2) run_en = 1'b0;
         @(negedge clk);
         exp_v = {k == 5, 1'b0, k <= 7};
         checks++;
         if ({div_valid, div_clk_en, busy} !== exp_v) begin
            errors++; $display("FAIL runen_seq k=%0d got %b exp %b", k, {div_valid, div_clk_en, busy}, exp_v);
         end
         if (k == 5) begin
            checks++;
            if (div !== 32'd7) begin
               errors++; $display("FAIL runen_div got %0d exp 7", div);
            end
         end
      end
      checks++;
      if (cur_div !== 32'd7) begin
         errors++; $display("FAIL runen_cur got %0d exp 7", cur_div);
      end
      tick;
      run_en = 1'b1;
      @(negedge clk);
      checks++;
      if (div_clk_en !== 1'b0) begin
         errors++; $display("FAIL runen_still_gated got %b exp 0", div_clk_en);
      end
      tick;
      @(negedge clk);
      checks++;
      if (div_clk_en !== 1'b1) begin
         errors++; $display("FAIL runen_reenable got %b exp 1", div_clk_en);
      end
   endtask

   task automatic test_reset_mid_settle;
      logic [2:0] exp_v;
      tick;
      req_valid = 4'b1000; req_div[96 +: 32] = 32'd9;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL rst_accept got %b exp 1000", req_ready);
      end
      for (int k = 1; k <= 6; k++) begin
         tick;
         if (k == 1) req_valid = '0;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b1 || cur_div !== 32'd9) begin
         errors++; $display("FAIL rst_in_settle got busy=%b cur=%0d exp 1/9", busy, cur_div);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({div_valid, div_clk_en, busy, err_zero} !== 4'b0000 || div !== 32'd1 || cur_div !== 32'd1) begin
         errors++;
         $display("FAIL rst_async got flags=%b div=%0d cur=%0d exp 0000/1/1", {div_valid, div_clk_en, busy, err_zero}, div, cur_div);
      end
      checks++;
      if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL rst_async_id got gid=%0d ready=%b exp 0/0000", grant_id, req_ready);
      end
      tick;
      tick;
      rstn = 1'b1;
      @(negedge clk);
      tick;
      @(negedge clk);
      checks++;
      if (div_clk_en !== 1'b1) begin
         errors++; $display("FAIL rst_release_en got %b exp 1", div_clk_en);
      end
      tick;
      req_valid = 4'b1000;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL rst_reissue got %b exp 1000", req_ready);
      end
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k == 1) req_valid = '0;
         @(negedge clk);
         exp_v = {k == 5, k == 8, k <= 7};
         checks++;
         if ({div_valid, div_clk_en, busy} !== exp_v) begin
            errors++; $display("FAIL rst_reissue_seq k=%0d got %b exp %b", k, {div_valid, div_clk_en, busy}, exp_v);
         end
      end
      checks++;
      if (cur_div !== 32'd9 || div !== 32'd9 || grant_id !== 2'd3) begin
         errors++; $display("FAIL rst_reissue_final got cur=%0d div=%0d gid=%0d exp 9/9/3", cur_div, div, grant_id);
      end
   endtask

   initial begin
      test_reset;
      test_single_ratio;
      test_round_robin;
      test_zero_and_same;
      test_run_en_gate;
      test_reset_mid_settle;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
